// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter
// Shares one single-port synchronous frame RAM between three masters.
// Master 0 is acquisition, master 1 is process and master 2 is readout.
// Each master uses a req/gnt handshake. A grant is held until the owner
// drops its req and is never pre-empted. While granted, the owner's access
// is muxed onto the RAM port. Read data comes back one cycle later with a
// per-master valid strobe.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   i_req / o_gnt     per-master request and registered one-hot grant
//   i_acc, i_we       per-master access strobe and write flag
//   i_addr, i_wdata   flat per-master buses, master k at slice k
//   o_rdata, o_rvalid read data (zero when idle) and per-master valid
//   o_ram_*           RAM port: enable, write enable, address, write data
//   i_ram_rdata       RAM read data, 1-cycle latency
//
// Build option: define FRAME_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (0 > 1 > 2). The default build uses round-robin.
module frame_ram_arbiter #(
  parameter int NB_ADC  = 12,
  parameter int NB_ADDR = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           i_req,
  output logic [2:0]           o_gnt,
  input  logic [2:0]           i_acc,
  input  logic [2:0]           i_we,
  input  logic [3*NB_ADDR-1:0] i_addr,
  input  logic [3*NB_ADC-1:0]  i_wdata,
  output logic [NB_ADC-1:0]    o_rdata,
  output logic [2:0]           o_rvalid,
  output logic                 o_ram_en,
  output logic                 o_ram_we,
  output logic [NB_ADDR-1:0]   o_ram_addr,
  output logic [NB_ADC-1:0]    o_ram_wdata,
  input  logic [NB_ADC-1:0]    i_ram_rdata
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] owner;
  logic [1:0] winner;
  logic [2:0] gnt;
  logic [2:0] rvalid;
  logic       access;

`ifndef FRAME_ARB_FIXED_PRIO_EN
  logic [1:0] last;
  logic [1:0] cand1;
  logic [1:0] cand2;
`endif

  // Winner selection for the IDLE state.
  always_comb begin
`ifdef FRAME_ARB_FIXED_PRIO_EN
    if (i_req[0])      winner = 2'd0;
    else if (i_req[1]) winner = 2'd1;
    else               winner = 2'd2;
`else
    // Search last+1, last+2, then last itself (all mod 3).
    cand1  = (last == 2'd2) ? 2'd0 : last + 2'd1;
    cand2  = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    if (i_req[cand1])      winner = cand1;
    else if (i_req[cand2]) winner = cand2;
    else                   winner = last;
`endif
  end

  // The owner's own req gates its access, so a releasing owner's i_acc is ignored.
  always_comb begin
    access      = (state == GRANT) && i_req[owner] && i_acc[owner];
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (access) begin
      o_ram_en    = 1'b1;
      o_ram_we    = i_we[owner];
      o_ram_addr  = i_addr[owner*NB_ADDR +: NB_ADDR];
      o_ram_wdata = i_wdata[owner*NB_ADC +: NB_ADC];
    end
  end

  assign o_gnt    = gnt;
  assign o_rvalid = rvalid;
  assign o_rdata  = (|rvalid) ? i_ram_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= 2'd0;
      gnt    <= '0;
      rvalid <= '0;
`ifndef FRAME_ARB_FIXED_PRIO_EN
      last   <= 2'd2;
`endif
    end else begin
      // The read target is captured at issue. The strobe therefore still
      // reaches the previous owner if the grant is released at N+1.
      rvalid <= (access && !i_we[owner]) ? (3'b001 << owner) : 3'b000;
      case (state)
        IDLE: begin
          if (|i_req) begin
            owner <= winner;
            gnt   <= 3'b001 << winner;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!i_req[owner]) begin
            gnt   <= '0;
            state <= IDLE;
`ifndef FRAME_ARB_FIXED_PRIO_EN
            last  <= owner;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_ram_arbiter.sv
module tb_frame_ram_arbiter;
  localparam int NB_ADC  = 12;
  localparam int NB_ADDR = 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [2:0]           i_req, o_gnt, i_acc, i_we, o_rvalid;
  logic [3*NB_ADDR-1:0] i_addr;
  logic [3*NB_ADC-1:0]  i_wdata;
  logic [NB_ADC-1:0]    o_rdata, o_ram_wdata, i_ram_rdata;
  logic                 o_ram_en, o_ram_we;
  logic [NB_ADDR-1:0]   o_ram_addr;

  logic [NB_ADC-1:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  frame_ram_arbiter #(.NB_ADC(NB_ADC), .NB_ADDR(NB_ADDR)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .o_gnt(o_gnt), .i_acc(i_acc),
    .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_rvalid(o_rvalid), .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
  );

  // Synchronous single-port RAM model with 1-cycle read latency.
  always @(posedge clk) begin
    if (o_ram_en) begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
      else          i_ram_rdata     <= mem[o_ram_addr];
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    i_req = '0; i_acc = '0; i_we = '0; i_addr = '0; i_wdata = '0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    clear_inputs();
    i_req = 3'b111; i_acc = 3'b111; i_we = 3'b111;
    step(); step(); step();
    total++; if (o_gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b exp=000", o_gnt); end
    total++; if (o_ram_en !== 1'b0) begin bad++; $display("FAIL reset_ram_en got=%b exp=0", o_ram_en); end
    total++; if (o_rvalid !== 3'b000) begin bad++; $display("FAIL reset_rvalid got=%b exp=000", o_rvalid); end
    total++; if (o_rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=000", o_rdata); end
    rst = 1'b1;
    step();
    total++; if (o_gnt !== 3'b001) begin bad++; $display("FAIL reset_first_gnt got=%b exp=001", o_gnt); end
    clear_inputs();
    step();
  endtask

  task automatic test_write_read_m1;
    do_reset();
    i_req = 3'b010;
    step();
    total++; if (o_gnt !== 3'b010) begin bad++; $display("FAIL wr_gnt got=%b exp=010", o_gnt); end
    i_acc = 3'b010; i_we = 3'b010;
    i_addr[1*NB_ADDR +: NB_ADDR] = 10'h005;
    i_wdata[1*NB_ADC +: NB_ADC]  = 12'h7FF;
    #1;
    total++; if ({o_ram_en, o_ram_we} !== 2'b11) begin bad++; $display("FAIL wr_en_we got=%b exp=11", {o_ram_en, o_ram_we}); end
    total++; if (o_ram_addr !== 10'h005) begin bad++; $display("FAIL wr_addr got=%h exp=005", o_ram_addr); end
    total++; if (o_ram_wdata !== 12'h7FF) begin bad++; $display("FAIL wr_data got=%h exp=7ff", o_ram_wdata); end
    step();
    i_we = 3'b000;
    #1;
    total++; if ({o_ram_en, o_ram_we} !== 2'b10) begin bad++; $display("FAIL rd_en_we got=%b exp=10", {o_ram_en, o_ram_we}); end
    step();
    i_acc = 3'b000;
    #1;
    total++; if (o_rvalid !== 3'b010) begin bad++; $display("FAIL rd_rvalid got=%b exp=010", o_rvalid); end
    total++; if (o_rdata !== 12'h7FF) begin bad++; $display("FAIL rd_rdata got=%h exp=7ff", o_rdata); end
    step();
    total++; if (o_rvalid !== 3'b000) begin bad++; $display("FAIL rd_rvalid_clear got=%b exp=000", o_rvalid); end
    total++; if (o_rdata !== '0) begin bad++; $display("FAIL rd_rdata_clear got=%h exp=000", o_rdata); end
    i_req = 3'b000;
    step();
    total++; if (o_gnt !== 3'b000) begin bad++; $display("FAIL wr_release got=%b exp=000", o_gnt); end
  endtask

  task automatic test_round_robin;
    int e;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      i_addr[k*NB_ADDR +: NB_ADDR] = NB_ADDR'(10'h100 + k);
      i_wdata[k*NB_ADC +: NB_ADC]  = NB_ADC'(12'h200 + k);
    end
    i_req = 3'b111;
    i_acc = 3'b111;
    i_we  = 3'b111;
    step();
    for (int i = 0; i < 4; i++) begin
`ifdef FRAME_ARB_FIXED_PRIO_EN
      e = 0;
`else
      e = i % 3;
`endif
      total++; if (o_gnt !== (3'b001 << e)) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, o_gnt, 3'b001 << e); end
      for (int a = 0; a < 2; a++) begin
        total++; if (o_ram_addr !== NB_ADDR'(10'h100 + e) || o_ram_en !== 1'b1)
          begin bad++; $display("FAIL rr_access[%0d] got en=%b addr=%h exp en=1 addr=%h", i, o_ram_en, o_ram_addr, 10'h100 + e); end
        step();
      end
      i_req = 3'b111 & ~(3'b001 << e);
      #1;
      total++; if (o_ram_en !== 1'b0) begin bad++; $display("FAIL rr_release_en[%0d] got=%b exp=0", i, o_ram_en); end
      step();
      total++; if (o_gnt !== 3'b000) begin bad++; $display("FAIL rr_idle_gnt[%0d] got=%b exp=000", i, o_gnt); end
      i_req = 3'b111;
      #1;
      total++; if (o_ram_en !== 1'b0) begin bad++; $display("FAIL rr_idle_en[%0d] got=%b exp=0", i, o_ram_en); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_read_across_release;
    do_reset();
    i_req = 3'b100;
    step();
    total++; if (o_gnt !== 3'b100) begin bad++; $display("FAIL rx_gnt got=%b exp=100", o_gnt); end
    i_acc = 3'b100; i_we = 3'b100;
    i_addr[2*NB_ADDR +: NB_ADDR] = 10'h23F;
    i_wdata[2*NB_ADC +: NB_ADC]  = 12'h5A5;
    step();
    i_we = 3'b000;
    #1;
    total++; if (o_ram_addr !== 10'h23F || o_ram_we !== 1'b0) begin bad++; $display("FAIL rx_read got addr=%h we=%b exp addr=23f we=0", o_ram_addr, o_ram_we); end
    step();
    i_req = 3'b000; i_acc = 3'b000;
    #1;
    total++; if (o_rvalid !== 3'b100) begin bad++; $display("FAIL rx_rvalid got=%b exp=100", o_rvalid); end
    total++; if (o_rdata !== 12'h5A5) begin bad++; $display("FAIL rx_rdata got=%h exp=5a5", o_rdata); end
    total++; if (o_ram_en !== 1'b0) begin bad++; $display("FAIL rx_release_en got=%b exp=0", o_ram_en); end
    step();
    total++; if (o_gnt !== 3'b000) begin bad++; $display("FAIL rx_gnt_drop got=%b exp=000", o_gnt); end
    total++; if (o_rvalid !== 3'b000 || o_rdata !== '0) begin bad++; $display("FAIL rx_rvalid_drop got=%b/%h exp=000/000", o_rvalid, o_rdata); end
  endtask

  task automatic test_isolation;
    do_reset();
    i_req = 3'b011;
    step();
    total++; if (o_gnt !== 3'b001) begin bad++; $display("FAIL iso_gnt got=%b exp=001", o_gnt); end
    i_acc = 3'b011; i_we = 3'b011;
    i_addr[0 +: NB_ADDR] = 10'h020;       i_wdata[0 +: NB_ADC] = 12'h123;
    i_addr[NB_ADDR +: NB_ADDR] = 10'h010; i_wdata[NB_ADC +: NB_ADC] = 12'hABC;
    #1;
    total++; if (o_ram_addr !== 10'h020 || o_ram_wdata !== 12'h123) begin bad++; $display("FAIL iso_owner got=%h/%h exp=020/123", o_ram_addr, o_ram_wdata); end
    i_acc = 3'b010;
    #1;
    total++; if ({o_ram_en, o_ram_we} !== 2'b00 || o_ram_addr !== '0 || o_ram_wdata !== '0)
      begin bad++; $display("FAIL iso_nonowner got en=%b we=%b addr=%h data=%h exp all 0", o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata); end
    step();
    total++; if (o_gnt !== 3'b001) begin bad++; $display("FAIL iso_hold got=%b exp=001", o_gnt); end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid_grant;
    do_reset();
    i_req = 3'b001;
    step();
    i_acc = 3'b001; i_we = 3'b001;
    i_addr[0 +: NB_ADDR] = 10'h030; i_wdata[0 +: NB_ADC] = 12'h456;
    #1;
    total++; if (o_ram_en !== 1'b1) begin bad++; $display("FAIL mid_pre_en got=%b exp=1", o_ram_en); end
    rst = 1'b0;
    #1;
    total++; if (o_ram_en !== 1'b0 || o_ram_we !== 1'b0 || o_ram_addr !== '0) begin bad++; $display("FAIL mid_async_ram got en=%b we=%b addr=%h exp 0", o_ram_en, o_ram_we, o_ram_addr); end
    total++; if (o_gnt !== 3'b000) begin bad++; $display("FAIL mid_async_gnt got=%b exp=000", o_gnt); end
    i_acc = 3'b000; i_we = 3'b000;
    i_req = 3'b011;
    step();
    rst = 1'b1;
    step();
    total++; if (o_gnt !== 3'b001) begin bad++; $display("FAIL mid_regrant got=%b exp=001", o_gnt); end
    i_acc = 3'b001;
    step();
    i_acc = 3'b000;
    #1;
    total++; if (o_rvalid !== 3'b001 || o_rdata !== 12'h000) begin bad++; $display("FAIL mid_no_write got=%b/%h exp=001/000", o_rvalid, o_rdata); end
    clear_inputs();
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    i_ram_rdata = '0;
    test_reset();
    test_write_read_m1();
    test_round_robin();
    test_read_across_release();
    test_isolation();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
